encoder_83_serializer: RTL and testbench



---
 rtl/enc_pkg.sv | 14 +
 rtl/encoder_83_serializer_prio_enc.sv | 31 +++
 rtl/encoder_83_serializer.sv | 126 ++++++++++++
 tb/tb_encoder_83_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and types for the 8-to-3 encoder serializer.
package enc_pkg;

  localparam int ENC_WIDTH  = 8;
  localparam int ENC_CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  typedef logic [ENC_CODE_W-1:0] enc_code_t;

endpackage

// File: rtl/encoder_83_serializer_prio_enc.sv
// Combinational find-first-set: lowest set index (MSB_FIRST=0) or highest (MSB_FIRST=1).
module prio_enc #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  localparam int CODE_W   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              found
);

  // Later loop iterations override earlier ones, so scan toward the winning end.
  always_comb begin
    code  = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        if (req[i]) begin
          code  = CODE_W'(i);
          found = 1'b1;
        end
      end else begin
        if (req[WIDTH-1-i]) begin
          code  = CODE_W'(WIDTH-1-i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/encoder_83_serializer.sv
// Serializes an accepted request vector into one binary index per output handshake.
// Optional macro ENC_POPCOUNT_EN adds req_count, the popcount of the accepted vector.
//
// state | meaning
// IDLE  | ready for a new vector, no code presented
// EMIT  | presenting the priority-encoded index of the pending mask
module encoder_83_serializer
  import enc_pkg::*;
#(
  parameter int WIDTH     = ENC_WIDTH,
  parameter int MSB_FIRST = 0,
  localparam int CODE_W   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
`ifdef ENC_POPCOUNT_EN
  output logic [CODE_W:0]   req_count,
`endif
  output logic              zero_drop
);

  enc_state_t        r_state;
  enc_state_t        w_state_nxt;
  logic [WIDTH-1:0]  r_pend;
  logic [WIDTH-1:0]  w_pend_nxt;
  logic              r_zero_drop;
  logic              w_zero_nxt;
  logic              w_accept;
  logic              w_found;
  logic              w_onehot;
  logic [WIDTH-1:0]  w_clr_mask;
  logic [CODE_W-1:0] w_code;

  prio_enc #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .req   (r_pend),
    .code  (w_code),
    .found (w_found)
  );

  assign w_onehot   = (r_pend != '0) && ((r_pend & (r_pend - WIDTH'(1))) == '0);
  assign w_clr_mask = WIDTH'(1) << w_code;

  assign req_ready = (r_state == IDLE);
  assign out_valid = (r_state == EMIT) && w_found;
  assign out_code  = w_code;
  assign out_last  = (r_state == EMIT) && w_onehot;
  assign zero_drop = r_zero_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_zero_nxt  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_vec != '0) begin
            w_pend_nxt  = req_vec;
            w_state_nxt = EMIT;
          end else begin
            w_zero_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_pend_nxt = r_pend & ~w_clr_mask;
          if (w_onehot) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_zero_drop <= w_zero_nxt;
    end
  end

`ifdef ENC_POPCOUNT_EN
  logic [CODE_W:0] r_count;
  logic [CODE_W:0] w_popcnt;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + {{CODE_W{1'b0}}, req_vec[i]};
    end
  end

  // An all-zero vector naturally counts to 0, so zero_drop accepts need no special case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_popcnt;
    end
  end

  assign req_count = r_count;
`else
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_encoder_83_serializer.sv
// Directed bench: one LSB-first and one MSB-first instance driven in lockstep.
module tb_encoder_83_serializer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_vec;
  logic       out_ready;

  logic       l_req_ready, l_out_valid, l_out_last, l_zero_drop;
  logic [2:0] l_out_code;
  logic       m_req_ready, m_out_valid, m_out_last, m_zero_drop;
  logic [2:0] m_out_code;
`ifdef ENC_POPCOUNT_EN
  logic [3:0] l_req_count, m_req_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  encoder_83_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (l_req_ready),
    .req_vec   (req_vec),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .out_code  (l_out_code),
    .out_last  (l_out_last),
`ifdef ENC_POPCOUNT_EN
    .req_count (l_req_count),
`endif
    .zero_drop (l_zero_drop)
  );

  encoder_83_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (m_req_ready),
    .req_vec   (req_vec),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_code  (m_out_code),
    .out_last  (m_out_last),
`ifdef ENC_POPCOUNT_EN
    .req_count (m_req_count),
`endif
    .zero_drop (m_zero_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for exactly one edge; afterwards req_vec is scrambled to prove it is ignored.
  task automatic send(input logic [7:0] vec);
    req_valid = 1'b1;
    req_vec   = vec;
    step();
    req_valid = 1'b0;
    req_vec   = 8'($urandom);
  endtask

  int         hs;
  int         exp_idx;
  logic [7:0] onehot;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_vec   = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
    chk("rst_out_code",  {26'd0, l_out_code, m_out_code}, 32'd0);
    chk("rst_out_last",  {30'd0, l_out_last, m_out_last}, 32'd0);
    chk("rst_zero_drop", {30'd0, l_zero_drop, m_zero_drop}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_req_ready", {30'd0, l_req_ready, m_req_ready}, 32'd3);
`ifdef ENC_POPCOUNT_EN
    chk("rst_req_count", {24'd0, l_req_count, m_req_count}, 32'd0);
`endif

    // Reset in the middle of a burst
    send(8'b1010_0110);
    chk("mid_first_valid", {30'd0, l_out_valid, m_out_valid}, 32'd3);
    chk("mid_first_code_lsb", 32'(l_out_code), 32'd1);
    chk("mid_first_code_msb", 32'(m_out_code), 32'd7);
    chk("mid_first_ready", {30'd0, l_req_ready, m_req_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("mid_second_code_lsb", 32'(l_out_code), 32'd2);
    chk("mid_second_code_msb", 32'(m_out_code), 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_async_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
    chk("mid_async_code",  {26'd0, l_out_code, m_out_code}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_after_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
      chk("mid_after_ready", {30'd0, l_req_ready, m_req_ready}, 32'd3);
    end

    // Single-bit vectors: inverse of the 3-to-8 decoder
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      onehot = 8'h01 << i;
      send(onehot);
      chk("single_valid", {30'd0, l_out_valid, m_out_valid}, 32'd3);
      chk("single_code_lsb", 32'(l_out_code), 32'(i));
      chk("single_code_msb", 32'(m_out_code), 32'(i));
      chk("single_last", {30'd0, l_out_last, m_out_last}, 32'd3);
      chk("single_decode", 32'(8'h01 << l_out_code), 32'(onehot));
      step();
      chk("single_bubble_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
      chk("single_bubble_ready", {30'd0, l_req_ready, m_req_ready}, 32'd3);
    end

    // Multi-bit vector 1001_0100: LSB-first 2,4,7; MSB-first 7,4,2
    send(8'b1001_0100);
    chk("multi0_code_lsb", 32'(l_out_code), 32'd2);
    chk("multi0_code_msb", 32'(m_out_code), 32'd7);
    chk("multi0_last", {30'd0, l_out_last, m_out_last}, 32'd0);
    step();
    chk("multi1_code_lsb", 32'(l_out_code), 32'd4);
    chk("multi1_code_msb", 32'(m_out_code), 32'd4);
    chk("multi1_last", {30'd0, l_out_last, m_out_last}, 32'd0);
    step();
    chk("multi2_code_lsb", 32'(l_out_code), 32'd7);
    chk("multi2_code_msb", 32'(m_out_code), 32'd2);
    chk("multi2_last", {30'd0, l_out_last, m_out_last}, 32'd3);
    chk("multi2_valid", {30'd0, l_out_valid, m_out_valid}, 32'd3);
    step();
    chk("multi_done_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
    chk("multi_done_ready", {30'd0, l_req_ready, m_req_ready}, 32'd3);

    // All-ones with random backpressure
    out_ready = 1'b0;
    send(8'hFF);
`ifdef ENC_POPCOUNT_EN
    chk("pop_ff", 32'(l_req_count), 32'd8);
`endif
    hs      = 0;
    exp_idx = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!l_out_valid) break;
      chk("bp_code_lsb", 32'(l_out_code), 32'(exp_idx));
      chk("bp_code_msb", 32'(m_out_code), 32'(7 - exp_idx));
      chk("bp_last", {30'd0, l_out_last, m_out_last}, (exp_idx == 7) ? 32'd3 : 32'd0);
      out_ready = 1'($urandom_range(0, 1));
      if (out_ready) begin
        hs++;
        exp_idx++;
      end
      step();
    end
    chk("bp_handshakes", 32'(hs), 32'd8);
    chk("bp_done_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
    chk("bp_done_ready", {30'd0, l_req_ready, m_req_ready}, 32'd3);
`ifdef ENC_POPCOUNT_EN
    chk("pop_ff_held", 32'(l_req_count), 32'd8);
`endif

    // Popcount held through the burst and into idle
    out_ready = 1'b1;
    send(8'b0011_0001);
`ifdef ENC_POPCOUNT_EN
    chk("pop_31", 32'(l_req_count), 32'd3);
`endif
    chk("p31_code0", 32'(l_out_code), 32'd0);
    step();
    chk("p31_code1", 32'(l_out_code), 32'd4);
    step();
    chk("p31_code2", 32'(l_out_code), 32'd5);
    chk("p31_last", {30'd0, l_out_last, m_out_last}, 32'd3);
    step();
    step();
`ifdef ENC_POPCOUNT_EN
    chk("pop_31_held", 32'(l_req_count), 32'd3);
`endif

    // Zero vector is dropped with a single-cycle pulse
    send(8'h00);
    chk("zero_pulse", {30'd0, l_zero_drop, m_zero_drop}, 32'd3);
    chk("zero_valid", {30'd0, l_out_valid, m_out_valid}, 32'd0);
    chk("zero_ready", {30'd0, l_req_ready, m_req_ready}, 32'd3);
`ifdef ENC_POPCOUNT_EN
    chk("zero_count", 32'(l_req_count), 32'd0);
`endif
    step();
    chk("zero_pulse_end", {30'd0, l_zero_drop, m_zero_drop}, 32'd0);
    chk("zero_valid_end", {30'd0, l_out_valid, m_out_valid}, 32'd0);
    chk("zero_ready_end", {30'd0, l_req_ready, m_req_ready}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
